// File: rtl/pipe_stage_buffer.sv
// rtl/pipe_stage_buffer.sv - elastic DEPTH-entry pipeline register with flush and stall/flush statistics
module pipe_stage_buffer #(
  parameter int CORE       = 0,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int CNT_BITS   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [CNT_BITS-1:0]     stall_cycles,
  output logic [CNT_BITS-1:0]     flushed_entries,
  input  logic                    report
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  push;
  logic                  pop;
  logic [CNT_BITS:0]     flush_sum;

  // Ready depends only on registered occupancy, so a full buffer never accepts on a same-cycle pop.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // One extra bit catches overflow so the flushed total can clamp instead of wrapping.
  always_comb begin
    flush_sum = {1'b0, flushed_entries} + (CNT_BITS+1)'(count);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles    <= '0;
      flushed_entries <= '0;
    end else begin
      if (in_valid && !in_ready && !flush && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (flush)
        flushed_entries <= flush_sum[CNT_BITS] ? '1 : flush_sum[CNT_BITS-1:0];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (report)
      $display("pipe_stage_buffer core %0d: count=%0d stall_cycles=%0d flushed_entries=%0d",
               CORE, count, stall_cycles, flushed_entries);
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// tb/tb_pipe_stage_buffer.sv - randomized and directed bench for pipe_stage_buffer against a queue model
module tb_pipe_stage_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CB    = 4;
  localparam int SAT   = (1 << CB) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [2:0]    count;
  logic [CB-1:0] stall_cycles;
  logic [CB-1:0] flushed_entries;
  logic          report = 1'b0;

  pipe_stage_buffer #(.CORE(0), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .stall_cycles(stall_cycles), .flushed_entries(flushed_entries),
    .report(report)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int pops_seen = 0;
  logic [DW-1:0] q[$];
  int m_stall = 0;
  int m_flushed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
    chk("flushed_entries", 64'(flushed_entries), 64'(m_flushed));
    if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
  endtask

  // Apply one cycle of inputs, compare at the falling edge, then advance the model.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    int n;
    in_valid = v; in_data = d; out_ready = r; flush = f;
    @(negedge clock);
    compare_model();
    n = q.size();
    if (f) begin
      m_flushed = (m_flushed + n > SAT) ? SAT : m_flushed + n;
      q.delete();
    end else begin
      if (v && n == DEPTH && m_stall < SAT) m_stall++;
      if (r && n != 0) begin
        void'(q.pop_front());
        pops_seen++;
      end
      if (v && n != DEPTH) q.push_back(d);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    q.delete(); m_stall = 0; m_flushed = 0;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst count", 64'(count), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst stall", 64'(stall_cycles), 64'd0);
    chk("rst flushed", 64'(flushed_entries), 64'd0);
    #2;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    do_reset();

    // Reset asserted mid-sequence with two entries held.
    step(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    step(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    chk("pre-reset count", 64'(count), 64'd2);
    do_reset();

    // Streaming, one push and one pop per cycle.
    pops_seen = 0;
    for (int i = 1; i <= 16; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream pops", 64'(pops_seen), 64'd16);
    chk("stream stall", 64'(stall_cycles), 64'd0);

    // Fill against back-pressure, then drain.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + DW'(i), 1'b0, 1'b0);
    chk("fill count", 64'(count), 64'd4);
    chk("fill stall", 64'(stall_cycles), 64'd2);
    chk("fill in_ready", 64'(in_ready), 64'd0);
    chk("fill head", 64'(out_data), 64'hA0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("drain in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush with three held entries and a concurrent push and pop.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'hF0 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("flush count", 64'(count), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush total", 64'(flushed_entries), 64'd3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Pointer wrap with occupancy alternating between one and two.
    do_reset();
    step(1'b1, 32'h5000, 1'b0, 1'b0);
    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 32'h5000 + DW'(i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("wrap count", 64'(count), 64'd1);
    chk("wrap head", 64'(out_data), 64'h500B);

    // Stall counter saturation.
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    chk("sat stall", 64'(stall_cycles), 64'd15);
    for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
    chk("sat stall hold", 64'(stall_cycles), 64'd15);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
